// File: rtl/gigerx_rdq_arbiter_pkg.sv
// rtl/gigerx_rdq_arbiter_pkg.sv - shared state encoding and defaults for the read-queue arbiter
package gigerx_rdq_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BURST = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    localparam int BURST_DEFAULT = 8;

endpackage

// File: rtl/gigerx_skid2.sv
// rtl/gigerx_skid2.sv - two-entry skid FIFO holding read data between queue and consumer
module gigerx_skid2 #(
    parameter int WIDTH = 65
) (
    input  logic             clk,
    input  logic             reset_,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       count
);

    logic [WIDTH-1:0] mem0, mem1;
    logic             rd_ptr, wr_ptr;
    logic             pop_eff;

    assign out_valid = (count != 2'd0);
    assign pop_eff   = pop & out_valid;
    // Head entry is never rewritten while occupied, so out_data holds during stalls.
    assign out_data  = rd_ptr ? mem1 : mem0;

    always_ff @(posedge clk) begin
        if (!reset_) begin
            mem0   <= '0;
            mem1   <= '0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                if (wr_ptr) mem1 <= push_data;
                else        mem0 <= push_data;
                wr_ptr <= ~wr_ptr;
            end
            if (pop_eff) rd_ptr <= ~rd_ptr;
            count <= count + {1'b0, push} - {1'b0, pop_eff};
        end
    end

endmodule

// File: rtl/gigerx_rdq_arbiter.sv
// rtl/gigerx_rdq_arbiter.sv - round-robin burst arbiter merging two read queues into one stream
module gigerx_rdq_arbiter
    import gigerx_rdq_arbiter_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int PTR   = 8,
    parameter int BURST = BURST_DEFAULT
) (
    input  logic             clk,
    input  logic             reset_,
    input  logic             enable,
    input  logic             q0_empty,
    input  logic             q1_empty,
    input  logic [PTR:0]     q0_usedw,
    input  logic [PTR:0]     q1_usedw,
    output logic             q0_rdreq,
    output logic             q1_rdreq,
    input  logic [WIDTH-1:0] q0_data,
    input  logic [WIDTH-1:0] q1_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_src,
    output logic             busy
);

    localparam int CW = $clog2(BURST + 1);

    state_t          state, state_nx;
    logic            rr, rr_nx;
    logic            gsel, gsel_nx;
    logic [CW-1:0]   cnt, cnt_nx;
    logic            inflight, inflight_src;
    logic [1:0]      skid_cnt;
    logic [2:0]      occ;
    logic            pop, room, rd, g_empty;
    logic [WIDTH:0]  skid_q;
    logic            unused_usedw;

    assign unused_usedw = ^{q0_usedw, q1_usedw};

    assign pop     = out_valid & out_ready;
    assign g_empty = gsel ? q1_empty : q0_empty;
    // Words buffered plus the one in flight must leave space after this cycle's pop.
    assign occ     = {1'b0, skid_cnt} + {2'b0, inflight};
    assign room    = occ < (3'd2 + {2'b0, pop});
    assign rd      = (state == ST_BURST) && !g_empty && room;

    assign q0_rdreq = rd & ~gsel;
    assign q1_rdreq = rd &  gsel;
    assign busy     = (state != ST_IDLE);

    always_comb begin
        state_nx = state;
        rr_nx    = rr;
        gsel_nx  = gsel;
        cnt_nx   = cnt;
        case (state)
            ST_IDLE: begin
                if (enable && (!q0_empty || !q1_empty)) begin
                    gsel_nx  = !q1_empty && (q0_empty || rr);
                    rr_nx    = ~gsel_nx;
                    cnt_nx   = '0;
                    state_nx = ST_BURST;
                end
            end
            ST_BURST: begin
                if (rd) cnt_nx = cnt + CW'(1);
                if ((rd && cnt == CW'(BURST - 1)) || (g_empty && cnt != '0))
                    state_nx = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (!inflight) state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_) begin
            state        <= ST_IDLE;
            rr           <= 1'b0;
            gsel         <= 1'b0;
            cnt          <= '0;
            inflight     <= 1'b0;
            inflight_src <= 1'b0;
        end else begin
            state        <= state_nx;
            rr           <= rr_nx;
            gsel         <= gsel_nx;
            cnt          <= cnt_nx;
            inflight     <= rd;
            inflight_src <= gsel;
        end
    end

    gigerx_skid2 #(.WIDTH(WIDTH + 1)) u_skid (
        .clk       (clk),
        .reset_    (reset_),
        .push      (inflight),
        .push_data ({inflight_src, inflight_src ? q1_data : q0_data}),
        .pop       (out_ready),
        .out_valid (out_valid),
        .out_data  (skid_q),
        .count     (skid_cnt)
    );

    assign out_data = skid_q[WIDTH-1:0];
    assign out_src  = skid_q[WIDTH];

endmodule
